// File: rtl/z80_clk_pkg.sv
// Shared types and constants for the Z80 clock generator.
package z80_clk_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK,
        RESET_HOLD,
        RUN,
        STOPPED,
        STEP
    } clk_state_t;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/z80_clkgen_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; resets to 0.
module sync_2ff
    import z80_clk_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/z80_clkgen.sv
// Derives cpu_clk from sys_clk by integer half-period division, sequences CPU reset after lock, run/stop/step.
// Optional rise counter on cycle_count enabled by `define CLKGEN_CYCLE_COUNT_EN.
module z80_clkgen
    import z80_clk_pkg::*;
#(
    parameter int DIV_W        = 8,
    parameter int DEFAULT_DIV  = 4,
    parameter int RESET_CYCLES = 16
) (
    input  logic             sys_clk,
    input  logic             reset_n,
    input  logic             pll_lock,
    input  logic [DIV_W-1:0] div_sel,
    input  logic             run,
    input  logic             step,
    output logic             cpu_clk,
    output logic             cpu_clk_rise,
    output logic             cpu_clk_fall,
    output logic             cpu_reset_n,
    output logic             stopped,
    output logic [31:0]      cycle_count
);

    localparam int RC_W = $clog2(RESET_CYCLES + 1);

    clk_state_t       state, state_nxt;
    logic             lock_s;
    logic [DIV_W-1:0] hp, hp_eff, sel_hp, cnt;
    logic [RC_W-1:0]  rst_cnt;
    logic             div_en, term, rise_evt, fall_evt, release_evt, step_take, step_armed;

    sync_2ff u_lock_sync (
        .clk   (sys_clk),
        .rst_n (reset_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    // The new half-period takes effect from the rise that latches it, so each period is uniform.
    assign sel_hp      = (div_sel == '0) ? DIV_W'(1) : div_sel;
    assign hp_eff      = cpu_clk_rise ? sel_hp : hp;
    assign term        = (cnt == hp_eff - DIV_W'(1));
    assign rise_evt    = div_en && term && !cpu_clk;
    assign fall_evt    = div_en && term && cpu_clk;
    assign release_evt = (state == RESET_HOLD) && fall_evt && (rst_cnt == RC_W'(RESET_CYCLES));
    assign step_take   = (state == STOPPED) && !run && step && step_armed;

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) state <= WAIT_LOCK;
        else          state <= state_nxt;
    end

    // With run low at reset release, RUN parks the clock high at the next rise.
    always_comb begin
        state_nxt = state;
        if (!lock_s) begin
            state_nxt = WAIT_LOCK;
        end else begin
            case (state)
                WAIT_LOCK:  state_nxt = RESET_HOLD;
                RESET_HOLD: if (release_evt) state_nxt = RUN;
                RUN:        if (rise_evt && !run) state_nxt = STOPPED;
                STOPPED:    if (run) state_nxt = RUN;
                            else if (step_take) state_nxt = STEP;
                STEP:       if (rise_evt) state_nxt = STOPPED;
                default:    state_nxt = WAIT_LOCK;
            endcase
        end
    end

    always_comb begin
        div_en  = 1'b0;
        stopped = 1'b0;
        case (state)
            RESET_HOLD, RUN, STEP: div_en  = 1'b1;
            STOPPED:               stopped = 1'b1;
            default:               ;
        endcase
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            hp           <= DIV_W'(DEFAULT_DIV);
            cnt          <= '0;
            cpu_clk      <= 1'b0;
            cpu_clk_rise <= 1'b0;
            cpu_clk_fall <= 1'b0;
            cpu_reset_n  <= 1'b0;
            rst_cnt      <= '0;
        end else if (!lock_s) begin
            // Forced low without a fall strobe: downstream must not see a legitimate edge.
            cnt          <= '0;
            cpu_clk      <= 1'b0;
            cpu_clk_rise <= 1'b0;
            cpu_clk_fall <= 1'b0;
            cpu_reset_n  <= 1'b0;
            rst_cnt      <= '0;
        end else begin
            cpu_clk_rise <= rise_evt;
            cpu_clk_fall <= fall_evt;
            if (cpu_clk_rise) hp <= sel_hp;
            if (!div_en) begin
                cnt <= '0;
            end else if (term) begin
                cnt     <= '0;
                cpu_clk <= ~cpu_clk;
            end else begin
                cnt <= cnt + DIV_W'(1);
            end
            if ((state == RESET_HOLD) && rise_evt && (rst_cnt != RC_W'(RESET_CYCLES)))
                rst_cnt <= rst_cnt + RC_W'(1);
            if (release_evt) cpu_reset_n <= 1'b1;
        end
    end

    // A held step is honoured once; it must be seen low before it can re-arm.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n)       step_armed <= 1'b0;
        else if (step_take) step_armed <= 1'b0;
        else if (!step)     step_armed <= 1'b1;
    end

`ifdef CLKGEN_CYCLE_COUNT_EN
    logic [31:0] cyc_q;

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n)                    cyc_q <= '0;
        else if (!lock_s)                cyc_q <= '0;
        else if (rise_evt && cpu_reset_n) cyc_q <= cyc_q + 32'd1;
    end

    assign cycle_count = cyc_q;
`else
    assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_z80_clkgen.sv
// Scoreboard bench for z80_clkgen: expected intervals/strobe patterns are queued as stimulus is applied.
`timescale 1ns/1ps
module tb_z80_clkgen;

    localparam int DIV_W = 8;
`ifdef CLKGEN_CYCLE_COUNT_EN
    localparam bit CC_EN = 1'b1;
`else
    localparam bit CC_EN = 1'b0;
`endif

    logic             sys_clk  = 1'b0;
    logic             reset_n  = 1'b0;
    logic             pll_lock = 1'b0;
    logic             run      = 1'b0;
    logic             step     = 1'b0;
    logic [DIV_W-1:0] div_sel  = 8'd4;
    logic             cpu_clk, cpu_clk_rise, cpu_clk_fall, cpu_reset_n, stopped;
    logic [31:0]      cycle_count;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   exp_q[$];
    logic prev_clk = 1'b0;

    z80_clkgen #(.DIV_W(DIV_W), .DEFAULT_DIV(4), .RESET_CYCLES(16)) dut (
        .sys_clk      (sys_clk),
        .reset_n      (reset_n),
        .pll_lock     (pll_lock),
        .div_sel      (div_sel),
        .run          (run),
        .step         (step),
        .cpu_clk      (cpu_clk),
        .cpu_clk_rise (cpu_clk_rise),
        .cpu_clk_fall (cpu_clk_fall),
        .cpu_reset_n  (cpu_reset_n),
        .stopped      (stopped),
        .cycle_count  (cycle_count)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Strobes must be one-hot and coincide with the matching cpu_clk transition.
    always @(negedge sys_clk) begin
        if (reset_n) begin
            checks++;
            if ((cpu_clk_rise && cpu_clk_fall) ||
                (cpu_clk_rise && !(cpu_clk && !prev_clk)) ||
                (cpu_clk_fall && !(!cpu_clk && prev_clk))) begin
                errors++;
                $display("FAIL strobe_edge: rise=%0b fall=%0b clk=%0b prev_clk=%0b, required one-hot strobe on matching edge",
                         cpu_clk_rise, cpu_clk_fall, cpu_clk, prev_clk);
            end
        end
        prev_clk = cpu_clk;
    end

    task automatic wait_strobe(input bit want_fall, input int budget, output bit ok, output int stamp);
        ok = 1'b0;
        stamp = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge sys_clk);
            if (want_fall ? cpu_clk_fall : cpu_clk_rise) begin
                ok = 1'b1;
                stamp = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        checks++;
        if ({cpu_clk, cpu_reset_n, cpu_clk_rise, cpu_clk_fall, stopped} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: clk/rst_n/rise/fall/stopped=%b required 00000",
                     {cpu_clk, cpu_reset_n, cpu_clk_rise, cpu_clk_fall, stopped});
        end
        checks++;
        if (cycle_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_cycle_count: got %0d required 0", cycle_count);
        end
    endtask

    task automatic test_bringup();
        int rises = 0, falls = 0, last_rise = -1, got, exp, rel_cc = -1, stamp;
        bit released = 1'b0, rel_on_fall = 1'b0, ok;
        run = 1'b1;
        div_sel = 8'd4;
        @(negedge sys_clk);
        reset_n = 1'b1;
        repeat (10) @(negedge sys_clk);
        pll_lock = 1'b1;
        for (int i = 0; i < 15; i++) exp_q.push_back(8);
        for (int i = 0; i < 400 && !released; i++) begin
            @(negedge sys_clk);
            if (cpu_clk_fall) falls++;
            if (cpu_clk_rise) begin
                rises++;
                if (last_rise >= 0 && exp_q.size() > 0) begin
                    got = cyc - last_rise;
                    exp = exp_q.pop_front();
                    checks++;
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL bringup_period: got %0d required %0d", got, exp);
                    end
                end
                last_rise = cyc;
            end
            if (cpu_reset_n) begin
                released = 1'b1;
                rel_on_fall = cpu_clk_fall;
                rel_cc = int'(cycle_count);
            end
        end
        checks++;
        if (!released || !rel_on_fall || falls != 16 || rises != 16) begin
            errors++;
            $display("FAIL bringup_release: released=%0b on_fall=%0b falls=%0d rises=%0d required 1 1 16 16",
                     released, rel_on_fall, falls, rises);
        end
        checks++;
        if (exp_q.size() != 0 || rel_cc != 0) begin
            errors++;
            $display("FAIL bringup_scoreboard: leftover=%0d cycle_count=%0d required 0 0", exp_q.size(), rel_cc);
        end
        exp_q.delete();
        for (int k = 1; k <= 3; k++) exp_q.push_back(CC_EN ? k : 0);
        for (int k = 1; k <= 3; k++) begin
            wait_strobe(1'b0, 20, ok, stamp);
            exp = exp_q.pop_front();
            checks++;
            if (!ok || cycle_count !== 32'(exp)) begin
                errors++;
                $display("FAIL cycle_count_inc: ok=%0b got %0d required %0d", ok, cycle_count, exp);
            end
        end
    endtask

    task automatic test_div_change();
        bit ok;
        int t0, t, prev, exp;
        wait_strobe(1'b0, 40, ok, t0);
        @(negedge sys_clk);
        @(negedge sys_clk);
        div_sel = 8'd2;
        exp_q.push_back(4); exp_q.push_back(4); exp_q.push_back(2); exp_q.push_back(2);
        prev = t0;
        for (int k = 0; k < 4; k++) begin
            wait_strobe(k % 2 == 0, 20, ok, t);
            exp = exp_q.pop_front();
            checks++;
            if (!ok || (t - prev) !== exp) begin
                errors++;
                $display("FAIL div_change_phase%0d: ok=%0b got %0d required %0d", k, ok, t - prev, exp);
            end
            prev = t;
        end
    endtask

    task automatic test_div_zero();
        bit ok;
        int t, exp, c6 = 0;
        wait_strobe(1'b0, 20, ok, t);
        @(negedge sys_clk);
        div_sel = 8'd0;
        wait_strobe(1'b0, 20, ok, t);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL div_zero_latch: no rise within budget, required one");
        end
        for (int i = 1; i <= 6; i++) exp_q.push_back((i % 2 == 0) ? 2 : 1);
        for (int i = 1; i <= 6; i++) begin
            @(negedge sys_clk);
            exp = exp_q.pop_front();
            checks++;
            if (int'({cpu_clk_rise, cpu_clk_fall}) !== exp) begin
                errors++;
                $display("FAIL div_zero_alt%0d: rise,fall=%b required %0d", i, {cpu_clk_rise, cpu_clk_fall}, exp);
            end
            if (i == 6) c6 = cyc;
        end
        div_sel = 8'd3;
        exp_q.push_back(6);
        wait_strobe(1'b0, 20, ok, t);
        exp = exp_q.pop_front();
        checks++;
        if (!ok || (t - c6) !== exp) begin
            errors++;
            $display("FAIL div3_period: ok=%0b got %0d required %0d", ok, t - c6, exp);
        end
    endtask

    task automatic test_stop_step();
        bit found = 1'b0, rise_at_stop = 1'b0, clk_at_stop = 1'b0;
        int lows = 0, rises = 0, falls = 0, strb = 0, first_fall = -1, first_rise = -1, exp;
        run = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge sys_clk);
            if (stopped) begin
                found = 1'b1;
                rise_at_stop = cpu_clk_rise;
                clk_at_stop = cpu_clk;
            end
        end
        checks++;
        if (!found || !rise_at_stop || !clk_at_stop) begin
            errors++;
            $display("FAIL stop_entry: stopped=%0b rise=%0b clk=%0b required 1 1 1", found, rise_at_stop, clk_at_stop);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            if (cpu_clk_rise || cpu_clk_fall || !cpu_clk || !stopped) strb++;
        end
        checks++;
        if (strb != 0) begin
            errors++;
            $display("FAIL stop_hold: %0d disturbed cycles required 0", strb);
        end
        // single step pulse, hp = 3
        exp_q.push_back(3); exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(1);
        step = 1'b1;
        for (int i = 1; i <= 40 && rises == 0; i++) begin
            @(negedge sys_clk);
            if (i == 1) step = 1'b0;
            if (!cpu_clk) lows++;
            if (cpu_clk_rise) rises++;
            if (cpu_clk_fall) falls++;
        end
        exp = exp_q.pop_front(); checks++;
        if (lows !== exp) begin errors++; $display("FAIL step_low_len: got %0d required %0d", lows, exp); end
        exp = exp_q.pop_front(); checks++;
        if (rises !== exp) begin errors++; $display("FAIL step_rises: got %0d required %0d", rises, exp); end
        exp = exp_q.pop_front(); checks++;
        if (falls !== exp) begin errors++; $display("FAIL step_falls: got %0d required %0d", falls, exp); end
        exp = exp_q.pop_front(); checks++;
        if (int'(stopped) !== exp) begin errors++; $display("FAIL step_restop: got %0b required %0d", stopped, exp); end
        // step held high: exactly one step
        repeat (3) @(negedge sys_clk);
        rises = 0; falls = 0;
        step = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            if (cpu_clk_rise) rises++;
            if (cpu_clk_fall) falls++;
        end
        step = 1'b0;
        checks++;
        if (rises != 1 || falls != 1 || !stopped) begin
            errors++;
            $display("FAIL step_held: rises=%0d falls=%0d stopped=%0b required 1 1 1", rises, falls, stopped);
        end
        // run and step together: run wins, first event is a fall
        repeat (2) @(negedge sys_clk);
        rises = 0;
        run = 1'b1;
        step = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge sys_clk);
            if (i == 1) step = 1'b0;
            if (cpu_clk_fall && first_fall < 0) first_fall = i;
            if (cpu_clk_rise) begin
                rises++;
                if (first_rise < 0) first_rise = i;
            end
        end
        checks++;
        if (first_fall != 4 || first_rise != 7 || rises != 3 || stopped) begin
            errors++;
            $display("FAIL run_over_step: first_fall=%0d first_rise=%0d rises=%0d stopped=%0b required 4 7 3 0",
                     first_fall, first_rise, rises, stopped);
        end
    endtask

    task automatic test_lock_loss();
        logic rst2 = 1'b0;
        logic [31:0] cc3 = 32'hffff_ffff;
        logic [3:0] v3 = 4'hf;
        int rises = 0;
        bit released = 1'b0;
        pll_lock = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge sys_clk);
            if (i == 2) rst2 = cpu_reset_n;
            if (i == 3) begin
                v3 = {cpu_reset_n, cpu_clk, cpu_clk_fall, cpu_clk_rise};
                cc3 = cycle_count;
            end
        end
        checks++;
        if (rst2 !== 1'b1) begin
            errors++;
            $display("FAIL lock_loss_sync_delay: cpu_reset_n=%0b after 2 edges required 1", rst2);
        end
        checks++;
        if (v3 !== 4'b0000 || cc3 !== 32'd0) begin
            errors++;
            $display("FAIL lock_loss_force: rst_n/clk/fall/rise=%b cycle_count=%0d required 0000 0", v3, cc3);
        end
        repeat (5) @(negedge sys_clk);
        pll_lock = 1'b1;
        for (int i = 0; i < 400 && !released; i++) begin
            @(negedge sys_clk);
            if (cpu_clk_rise) rises++;
            if (cpu_reset_n) released = 1'b1;
        end
        checks++;
        if (!released || rises != 16) begin
            errors++;
            $display("FAIL relock_hold: released=%0b rises=%0d required 1 16", released, rises);
        end
    endtask

    task automatic test_async_reset();
        bit found = 1'b0, in_step = 1'b0;
        run = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge sys_clk);
            if (stopped) found = 1'b1;
        end
        repeat (2) @(negedge sys_clk);
        step = 1'b1;
        for (int i = 1; i <= 10 && !in_step; i++) begin
            @(negedge sys_clk);
            if (i == 1) step = 1'b0;
            if (!cpu_clk && !stopped && cpu_reset_n) in_step = 1'b1;
        end
        checks++;
        if (!found || !in_step) begin
            errors++;
            $display("FAIL step_setup: stopped_seen=%0b low_phase_seen=%0b required 1 1", found, in_step);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({cpu_clk, cpu_reset_n, cpu_clk_rise, cpu_clk_fall, stopped} !== 5'b0 || cycle_count !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: clk/rst_n/rise/fall/stopped=%b cycle_count=%0d required 00000 0",
                     {cpu_clk, cpu_reset_n, cpu_clk_rise, cpu_clk_fall, stopped}, cycle_count);
        end
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_div_change();
        test_div_zero();
        test_stop_step();
        test_lock_loss();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
